busctrl_param: RTL and testbench

- Parametrised successor to the fixed ECO32 bus controller. Routes single CPU bus transactions to NUM_SLV slaves through a parameter-driven base/mask address map.
- Adds features the fixed decoder lacks: a registered decode stage, a per-access timeout watchdog, misalignment and unmapped-address detection, and a sticky error-capture register.
- Sits between Cpu and the device blocks (ram, rom, tmr, dsp, kbd, ser, dsk) in the toplevel.

---
 rtl/busctrl_pkg.sv | 30 +++
 rtl/addr_decode.sv | 57 +++++
 rtl/busctrl_param.sv | 172 +++++++++++++++++
 tb/tb_busctrl_param.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/busctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : busctrl_pkg
//  Description : Shared types and helpers for the parametrised bus controller:
//                access-size encodings, controller state type and the
//                watchdog counter width function.
//  Revision    : 1.0  initial release
// ============================================================================
package busctrl_pkg;

    // CPU access-size encodings
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Controller states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ERR    = 2'd2
    } state_t;

    // Width needed to hold 0..timeout without wrapping
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/addr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : addr_decode
//  Description : Combinational base/mask address matcher with lowest-index
//                priority, plus access alignment check.
//  Revision    : 1.0  initial release
// ============================================================================
module addr_decode
    import busctrl_pkg::*;
#(
    parameter int                      NUM_SLV  = 8,
    parameter logic [32*NUM_SLV-1:0]   SLV_BASE = {NUM_SLV{32'h0}},
    parameter logic [32*NUM_SLV-1:0]   SLV_MASK = {NUM_SLV{32'hFFFFFFFF}},
    parameter int                      IDX_W    = 3
) (
    input  logic [31:0]      i_addr,
    input  logic [1:0]       i_size,
    output logic             o_hit,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_misaligned
);

    logic [NUM_SLV-1:0] w_hit_vec;

    generate
        for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_match
            assign w_hit_vec[gi] =
                ((i_addr & SLV_MASK[32*gi +: 32]) == SLV_BASE[32*gi +: 32]);
        end
    endgenerate

    assign o_hit = |w_hit_vec;

    // Priority encode: scan downward so the lowest matching index is kept
    always_comb begin
        o_idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (w_hit_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    // Halfwords need even addresses, words need 4-byte alignment
    always_comb begin
        o_misaligned = 1'b0;
        case (i_size)
            SZ_BYTE: o_misaligned = 1'b0;
            SZ_HALF: o_misaligned = i_addr[0];
            SZ_WORD: o_misaligned = (i_addr[1:0] != 2'b00);
            SZ_ILL:  o_misaligned = 1'b1;
            default: o_misaligned = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/busctrl_param.sv
`default_nettype none
// ============================================================================
//  Module      : busctrl_param
//  Description : Parametrised CPU bus controller. Registered decode stage,
//                one-hot slave select, per-access timeout watchdog and a
//                sticky first-fault capture register.
//  Revision    : 1.0  initial release
// ============================================================================
module busctrl_param
    import busctrl_pkg::*;
#(
    parameter int                    NUM_SLV  = 8,
    parameter logic [32*NUM_SLV-1:0] SLV_BASE = {NUM_SLV{32'h0}},
    parameter logic [32*NUM_SLV-1:0] SLV_MASK = {NUM_SLV{32'hFFFFFFFF}},
    parameter int                    TIMEOUT  = 255
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cpu_en,
    input  logic                    cpu_wr,
    input  logic [1:0]              cpu_size,
    input  logic [31:0]             cpu_addr,
    input  logic [31:0]             cpu_data_out,
    output logic [31:0]             cpu_data_in,
    output logic                    cpu_wt,
    output logic                    bus_err,
    output logic                    err_valid,
    output logic [31:0]             err_addr,
    input  logic                    err_clr,
    output logic [NUM_SLV-1:0]      slv_en,
    output logic                    slv_wr,
    output logic [1:0]              slv_size,
    output logic [31:0]             slv_addr,
    output logic [31:0]             slv_wdata,
    input  logic [32*NUM_SLV-1:0]   slv_rdata,
    input  logic [NUM_SLV-1:0]      slv_wt
);

    localparam int                 c_idx_w    = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int                 c_cnt_w    = cnt_width(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_idx_w-1:0]   r_sel;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic                 r_err_valid;
    logic [31:0]          r_err_addr;

    logic                 w_hit;
    logic [c_idx_w-1:0]   w_idx;
    logic                 w_misaligned;

    logic [NUM_SLV-1:0]   w_sel_onehot;
    logic                 w_sel_wt;
    logic [31:0]          w_sel_rdata;
    logic [31:0]          w_sel_mask;

    addr_decode #(
        .NUM_SLV  (NUM_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK),
        .IDX_W    (c_idx_w)
    ) u_decode (
        .i_addr       (cpu_addr),
        .i_size       (cpu_size),
        .o_hit        (w_hit),
        .o_idx        (w_idx),
        .o_misaligned (w_misaligned)
    );

    // Route the latched slave's wait, read data and mask to shared signals
    always_comb begin
        w_sel_onehot = '0;
        w_sel_wt     = 1'b0;
        w_sel_rdata  = '0;
        w_sel_mask   = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (r_sel == c_idx_w'(i)) begin
                w_sel_onehot[i] = 1'b1;
                w_sel_wt        = slv_wt[i];
                w_sel_rdata     = slv_rdata[32*i +: 32];
                w_sel_mask      = SLV_MASK[32*i +: 32];
            end
        end
    end

    // State, selected slave and watchdog counter registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == ST_IDLE) begin
                r_sel <= w_idx;
            end
        end
    end

    // Next-state logic and CPU/slave handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        slv_en      = '0;
        cpu_wt      = 1'b1;
        cpu_data_in = '0;
        bus_err     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_en) begin
                    w_cnt_nxt = '0;
                    if (w_misaligned || !w_hit) begin
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_state_nxt = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                slv_en      = w_sel_onehot;
                cpu_wt      = w_sel_wt;
                cpu_data_in = cpu_wr ? 32'h0 : w_sel_rdata;
                if (!cpu_en) begin
                    // CPU withdrew the request: silent abort
                    w_state_nxt = ST_IDLE;
                end else if (!w_sel_wt) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = ST_ERR;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            ST_ERR: begin
                cpu_wt      = 1'b0;
                bus_err     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sticky first-fault capture; a capture takes precedence over a clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_err_valid <= 1'b0;
            r_err_addr  <= '0;
        end else if ((r_state == ST_ERR) && (!r_err_valid || err_clr)) begin
            r_err_valid <= 1'b1;
            r_err_addr  <= cpu_addr;
        end else if (err_clr) begin
            r_err_valid <= 1'b0;
        end
    end

    assign err_valid = r_err_valid;
    assign err_addr  = r_err_addr;

    // Slave-side request fields follow the CPU, which holds them stable
    assign slv_wr    = cpu_wr;
    assign slv_size  = cpu_size;
    assign slv_wdata = cpu_data_out;
    assign slv_addr  = cpu_addr & ~w_sel_mask;

endmodule
`default_nettype wire

// File: tb/tb_busctrl_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_busctrl_param
//  Description : Self-checking bench for busctrl_param with a three-slave map
//                (RAM, ROM, TMR) and an expected-completion scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_busctrl_param;

    localparam int          NSLV  = 3;
    localparam logic [95:0] BASE  = {32'h30000000, 32'h20000000, 32'h00000000};
    localparam logic [95:0] MASK  = {32'hFFFFFFF0, 32'hFFE00000, 32'hE0000000};
    localparam logic [31:0] DAT0  = 32'h1111_0000;
    localparam logic [31:0] DAT1  = 32'h2222_0000;
    localparam logic [31:0] DAT2  = 32'h3333_0000;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             cpu_en, cpu_wr, err_clr;
    logic [1:0]       cpu_size;
    logic [31:0]      cpu_addr, cpu_data_out, cpu_data_in;
    logic             cpu_wt, bus_err, err_valid;
    logic [31:0]      err_addr;
    logic [NSLV-1:0]  slv_en;
    logic             slv_wr;
    logic [1:0]       slv_size;
    logic [31:0]      slv_addr, slv_wdata;
    logic [95:0]      slv_rdata;
    logic [NSLV-1:0]  slv_wt;

    int               en_cnt [NSLV];
    int               hold   [NSLV];
    int               vec_cnt  = 0;
    int               miss_cnt = 0;

    typedef struct {
        logic            err;
        logic [31:0]     data;
        int              len;
        int              en_cycles;
        logic [NSLV-1:0] en;
        logic [31:0]     saddr;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    busctrl_param #(
        .NUM_SLV  (NSLV),
        .SLV_BASE (BASE),
        .SLV_MASK (MASK),
        .TIMEOUT  (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_en       (cpu_en),
        .cpu_wr       (cpu_wr),
        .cpu_size     (cpu_size),
        .cpu_addr     (cpu_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_data_in  (cpu_data_in),
        .cpu_wt       (cpu_wt),
        .bus_err      (bus_err),
        .err_valid    (err_valid),
        .err_addr     (err_addr),
        .err_clr      (err_clr),
        .slv_en       (slv_en),
        .slv_wr       (slv_wr),
        .slv_size     (slv_size),
        .slv_addr     (slv_addr),
        .slv_wdata    (slv_wdata),
        .slv_rdata    (slv_rdata),
        .slv_wt       (slv_wt)
    );

    assign slv_rdata = {DAT2, DAT1, DAT0};

    // Slave models: hold wait for hold[i] enabled cycles, then release
    always @(posedge clk) begin
        for (int i = 0; i < NSLV; i++) begin
            en_cnt[i] <= slv_en[i] ? en_cnt[i] + 1 : 0;
        end
    end

    always_comb begin
        slv_wt = '0;
        for (int i = 0; i < NSLV; i++) begin
            slv_wt[i] = slv_en[i] && (en_cnt[i] < hold[i]);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic err, input logic [31:0] data, input int len,
                                input int en_cycles, input logic [NSLV-1:0] en,
                                input logic [31:0] saddr);
        exp_t e;
        e.err = err; e.data = data; e.len = len;
        e.en_cycles = en_cycles; e.en = en; e.saddr = saddr;
        return e;
    endfunction

    // Issue one access, keep cpu_en up until the DUT releases cpu_wt
    task automatic access(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                          input logic [31:0] wdata, input exp_t e);
        exp_t g;
        int   cyc, en_cyc;
        bit   done, saw_en;
        @(posedge clk); #1;
        cpu_en = 1'b1; cpu_wr = wr; cpu_size = size;
        cpu_addr = addr; cpu_data_out = wdata;
        sb_q.push_back(e);
        cyc = 0; en_cyc = 0; done = 0; saw_en = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("decode_wt", {31'h0, cpu_wt}, 32'h1);
                check("idle_berr", {31'h0, bus_err}, 32'h0);
            end
            if (slv_en != '0) begin
                en_cyc++;
                if (!saw_en) begin
                    saw_en = 1;
                    check("slv_en", {29'h0, slv_en}, {29'h0, e.en});
                    check("slv_addr", slv_addr, e.saddr);
                    check("slv_wdata", slv_wdata, wdata);
                end
            end
            if (cpu_wt == 1'b0) begin
                done = 1;
                g = sb_q.pop_front();
                check("bus_err", {31'h0, bus_err}, {31'h0, g.err});
                check("rdata", cpu_data_in, g.data);
                check("latency", cyc, g.len);
                check("en_cycles", en_cyc, g.en_cycles);
                check("done_en", {29'h0, slv_en}, g.err ? 32'h0 : {29'h0, g.en});
            end
        end
        if (!done) begin
            g = sb_q.pop_front();
            check("completion_bound", 32'h0, 32'h1);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        cpu_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_cpu_wt"}, {31'h0, cpu_wt}, 32'h1);
        check({pfx, "_slv_en"}, {29'h0, slv_en}, 32'h0);
        check({pfx, "_bus_err"}, {31'h0, bus_err}, 32'h0);
        check({pfx, "_data_in"}, cpu_data_in, 32'h0);
        check({pfx, "_err_valid"}, {31'h0, err_valid}, 32'h0);
        check({pfx, "_err_addr"}, err_addr, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hold[0] = 0; hold[1] = 1000; hold[2] = 3;
        for (int i = 0; i < NSLV; i++) en_cnt[i] = 0;
        reset_n = 1'b0; cpu_en = 1'b0; cpu_wr = 1'b0; cpu_size = 2'b10;
        cpu_addr = '0; cpu_data_out = '0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        reset_n = 1'b1;

        // RAM word read, slave answers at once; then back-to-back byte write
        access(32'h0000_1004, 1'b0, 2'b10, 32'h0, mk(1'b0, DAT0, 2, 1, 3'b001, 32'h0000_1004));
        access(32'h0000_0003, 1'b1, 2'b00, 32'hA5, mk(1'b0, 32'h0, 2, 1, 3'b001, 32'h0000_0003));

        // TMR write with three wait cycles
        access(32'h3000_0008, 1'b1, 2'b10, 32'hCAFE_F00D, mk(1'b0, 32'h0, 5, 4, 3'b100, 32'h0000_0008));
        idle_cycle();
        check("pre_err_valid", {31'h0, err_valid}, 32'h0);

        // Unmapped read
        access(32'h4000_0000, 1'b0, 2'b10, 32'h0, mk(1'b1, 32'h0, 2, 0, 3'b000, 32'h0));
        idle_cycle();
        check("unmap_err_valid", {31'h0, err_valid}, 32'h1);
        check("unmap_err_addr", err_addr, 32'h4000_0000);
        check("berr_pulse", {31'h0, bus_err}, 32'h0);

        // ROM never releases wait: 8 access cycles then a bus error
        access(32'h2000_0100, 1'b0, 2'b10, 32'h0, mk(1'b1, 32'h0, 10, 8, 3'b010, 32'h0000_0100));
        idle_cycle();
        check("tmo_err_addr_kept", err_addr, 32'h4000_0000);
        check("tmo_berr_pulse", {31'h0, bus_err}, 32'h0);
        check("tmo_slv_en_off", {29'h0, slv_en}, 32'h0);

        // Clear the sticky flag
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        @(negedge clk);
        check("clr_err_valid", {31'h0, err_valid}, 32'h0);

        // Misaligned halfword, then illegal size
        access(32'h0000_0001, 1'b0, 2'b01, 32'h0, mk(1'b1, 32'h0, 2, 0, 3'b000, 32'h0));
        access(32'h0000_0000, 1'b0, 2'b11, 32'h0, mk(1'b1, 32'h0, 2, 0, 3'b000, 32'h0));
        idle_cycle();
        check("mis_err_valid", {31'h0, err_valid}, 32'h1);
        check("mis_err_addr", err_addr, 32'h0000_0001);

        // Reset while a ROM access is stalled
        @(posedge clk); #1;
        cpu_en = 1'b1; cpu_wr = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h2000_0000;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_en", {29'h0, slv_en}, 32'h2);
        reset_n = 1'b0;
        cpu_en  = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        reset_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
`default_nettype wire
